// File: rtl/dma_copy_if.sv
// Bundled register-port and memory-port signals of the dma_copy block.
// The master side is the DMA engine; the slave side is the CPU/memory environment.
interface dma_copy_if;
   logic [1:0]  cfg_addr;
   logic        cfg_we;
   logic [31:0] cfg_wd;
   logic [31:0] cfg_rd;
   logic [31:0] mem_addr;
   logic        mem_we;
   logic [31:0] mem_wd;
   logic        mem_req;
   logic        mem_gnt;
   logic [31:0] mem_rd;
   logic        irq;

   modport master (
      input  cfg_addr, cfg_we, cfg_wd, mem_gnt, mem_rd,
      output cfg_rd, mem_addr, mem_we, mem_wd, mem_req, irq
   );

   modport slave (
      output cfg_addr, cfg_we, cfg_wd, mem_gnt, mem_rd,
      input  cfg_rd, mem_addr, mem_we, mem_wd, mem_req, irq
   );
endinterface

// File: rtl/dma_copy.sv
// Single-channel word-copy DMA: reads SRC, writes DST, one word per READ/WRITE pair,
// LEN words total, with abort, done/interrupt and live register readback.
module dma_copy (
   input logic        clk,
   input logic        reset,
   dma_copy_if.master bus
);
   typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;

   state_t      state;
   logic [31:0] src;
   logic [31:0] dst;
   logic [31:0] data;
   logic [15:0] len;
   logic        im;
   logic        done;

   logic        busy;
   logic        ctrl_wr;
   logic        abort;
   logic        reg_wr;
   logic [15:0] len_next;

   assign busy     = (state == READ) || (state == WRITE);
   assign ctrl_wr  = bus.cfg_we && (bus.cfg_addr == 2'd0);
   assign abort    = ctrl_wr && !bus.cfg_wd[0];
   assign reg_wr   = bus.cfg_we && !busy;
   assign len_next = len - 16'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         src   <= 32'd0;
         dst   <= 32'd0;
         data  <= 32'd0;
         len   <= 16'd0;
         im    <= 1'b0;
         done  <= 1'b0;
      end else begin
         if (ctrl_wr) begin
            im <= bus.cfg_wd[1];
            if (bus.cfg_wd[2]) done <= 1'b0;
         end

         if (reg_wr) begin
            case (bus.cfg_addr)
               2'd1:    src <= {bus.cfg_wd[31:2], 2'b00};
               2'd2:    dst <= {bus.cfg_wd[31:2], 2'b00};
               2'd3:    len <= bus.cfg_wd[15:0];
               default: ;
            endcase
         end

         // NOTE: non-blocking assignments resolve to the last one written in this block,
         // so the done set below deliberately overrides the W1C clear above.
         case (state)
            IDLE: begin
               if (ctrl_wr && bus.cfg_wd[0]) begin
                  if (len != 16'd0) state <= READ;
                  else              done  <= 1'b1;
               end
            end
            READ: begin
               if (abort) begin
                  state <= IDLE;
               end else if (bus.mem_gnt) begin
                  data  <= bus.mem_rd;
                  state <= WRITE;
               end
            end
            WRITE: begin
               if (abort) begin
                  state <= IDLE;
               end else if (bus.mem_gnt) begin
                  src   <= src + 32'd4;
                  dst   <= dst + 32'd4;
                  len   <= len_next;
                  state <= (len_next == 16'd0) ? FINISH : READ;
               end
            end
            FINISH: begin
               done  <= 1'b1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Memory port is a pure decode of registered state, so it holds steady while stalled.
   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      bus.mem_req  = busy;
      bus.mem_we   = 1'b0;
      bus.mem_addr = 32'd0;
      bus.mem_wd   = 32'd0;
      case (state)
         READ:  bus.mem_addr = src;
         WRITE: begin
            bus.mem_addr = dst;
            bus.mem_we   = 1'b1;
            bus.mem_wd   = data;
         end
         default: ;
      endcase
   end

   always_comb begin
      bus.cfg_rd = 32'd0;
      case (bus.cfg_addr)
         2'd0: bus.cfg_rd = {29'd0, done, im, busy};
         2'd1: bus.cfg_rd = src;
         2'd2: bus.cfg_rd = dst;
         2'd3: bus.cfg_rd = {16'd0, len};
      endcase
   end

   assign bus.irq = done & im;
endmodule

// File: tb/tb_dma_copy.sv
// Directed bench for dma_copy: register table plus hand-built transfer, stall,
// wrap, abort and reset sequences against a pattern-generating memory model.
module tb_dma_copy;
   logic clk = 1'b0;
   logic reset;
   always #10 clk = ~clk;

   dma_copy_if bus ();

   dma_copy dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int tests = 0;
   int fails = 0;

   // 0: grant every cycle; 1: grant on the third cycle of each access
   logic        gnt_mode;
   logic [1:0]  wait_cnt;
   logic [31:0] req_q[$];
   logic [31:0] rd_addr_q[$];
   logic [31:0] wr_addr_q[$];
   logic [31:0] wr_data_q[$];

   function automatic logic [31:0] pat(input logic [31:0] a);
      return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
   endfunction

   assign bus.mem_rd  = pat(bus.mem_addr);
   assign bus.mem_gnt = (gnt_mode == 1'b0) ? 1'b1 : (wait_cnt == 2'd2);

   always @(posedge clk or posedge reset) begin
      if (reset)                            wait_cnt <= 2'd0;
      else if (bus.mem_req && !bus.mem_gnt) wait_cnt <= wait_cnt + 2'd1;
      else                                  wait_cnt <= 2'd0;
   end

   always @(posedge clk) begin
      if (!reset && bus.mem_req) begin
         req_q.push_back(bus.mem_addr);
         if (bus.mem_gnt) begin
            if (bus.mem_we) begin
               wr_addr_q.push_back(bus.mem_addr);
               wr_data_q.push_back(bus.mem_wd);
            end else begin
               rd_addr_q.push_back(bus.mem_addr);
            end
         end
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
      bus.cfg_addr = a;
      bus.cfg_we   = 1'b1;
      bus.cfg_wd   = d;
      tick();
      bus.cfg_we   = 1'b0;
      bus.cfg_wd   = 32'd0;
   endtask

   task automatic check_reg(input string name, input logic [1:0] a, input logic [31:0] exp);
      bus.cfg_addr = a;
      #1;
      check(name, bus.cfg_rd, exp);
   endtask

   task automatic wait_done(input int budget, output int cycles);
      bus.cfg_addr = 2'd0;
      cycles = 0;
      while (cycles < budget) begin
         tick();
         cycles++;
         if (bus.cfg_rd[2]) break;
      end
   endtask

   typedef struct packed {
      logic [1:0]  addr;
      logic        we;
      logic [31:0] wd;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[8];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int          bw, br, brq, cyc;
      logic [31:0] exp_addr, exp_wd;
      logic        exp_we;

      vecs[0] = '{2'd0, 1'b0, 32'h0000_0000, 32'h0000_0000};
      vecs[1] = '{2'd1, 1'b1, 32'h0000_0103, 32'h0000_0100};
      vecs[2] = '{2'd2, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFC};
      vecs[3] = '{2'd3, 1'b1, 32'h0001_2345, 32'h0000_2345};
      vecs[4] = '{2'd0, 1'b1, 32'h0000_0002, 32'h0000_0002};
      vecs[5] = '{2'd0, 1'b1, 32'h0000_0000, 32'h0000_0000};
      vecs[6] = '{2'd3, 1'b1, 32'h0000_0000, 32'h0000_0000};
      vecs[7] = '{2'd1, 1'b1, 32'hABCD_0001, 32'hABCD_0000};

      reset        = 1'b1;
      gnt_mode     = 1'b0;
      bus.cfg_addr = 2'd0;
      bus.cfg_we   = 1'b0;
      bus.cfg_wd   = 32'd0;
      #3;
      check("rst_mem_req",  32'(bus.mem_req), 32'd0);
      check("rst_mem_we",   32'(bus.mem_we),  32'd0);
      check("rst_mem_addr", bus.mem_addr,     32'd0);
      check("rst_mem_wd",   bus.mem_wd,       32'd0);
      check("rst_irq",      32'(bus.irq),     32'd0);
      check("rst_ctrl",     bus.cfg_rd,       32'd0);
      @(negedge clk);
      reset = 1'b0;
      tick();

      // register access table (idle)
      for (int i = 0; i < 8; i++) begin
         if (vecs[i].we) cfg_write(vecs[i].addr, vecs[i].wd);
         check_reg($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
      end

      // 3-word copy with constant grant, im=1
      bw = wr_addr_q.size();
      cfg_write(2'd1, 32'h100);
      cfg_write(2'd2, 32'h200);
      cfg_write(2'd3, 32'd3);
      cfg_write(2'd0, 32'h3);
      check("a_first_req",  32'(bus.mem_req), 32'd1);
      check("a_first_addr", bus.mem_addr,     32'h100);
      bus.cfg_addr = 2'd0;
      repeat (6) tick();
      check("a_ctrl_finish", bus.cfg_rd, 32'h2);
      tick();
      check("a_ctrl_done", bus.cfg_rd,   32'h6);
      check("a_irq",       32'(bus.irq), 32'd1);
      check("a_nwrites",   32'(wr_addr_q.size() - bw), 32'd3);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("a_wr%0d_addr", k), wr_addr_q[bw + k], 32'h200 + 32'(4 * k));
         check($sformatf("a_wr%0d_data", k), wr_data_q[bw + k], pat(32'h100 + 32'(4 * k)));
      end
      check_reg("a_src", 2'd1, 32'h10C);
      check_reg("a_dst", 2'd2, 32'h20C);
      check_reg("a_len", 2'd3, 32'h0);
      cfg_write(2'd0, 32'h4);
      check_reg("a_ctrl_clr", 2'd0, 32'h0);
      check("a_irq_clr", 32'(bus.irq), 32'd0);

      // LEN==0 start: immediate done, no memory traffic
      brq = req_q.size();
      cfg_write(2'd0, 32'h1);
      check_reg("b_ctrl_done", 2'd0, 32'h4);
      check("b_irq", 32'(bus.irq), 32'd0);
      repeat (3) tick();
      check("b_no_req", 32'(req_q.size() - brq), 32'd0);
      cfg_write(2'd0, 32'h4);
      check_reg("b_ctrl_clr", 2'd0, 32'h0);

      // 2-word copy with grant 0,0,1 per access: outputs held while stalled
      gnt_mode = 1'b1;
      bw = wr_addr_q.size();
      cfg_write(2'd1, 32'h300);
      cfg_write(2'd2, 32'h400);
      cfg_write(2'd3, 32'd2);
      cfg_write(2'd0, 32'h1);
      for (int acc = 0; acc < 4; acc++) begin
         exp_we   = acc[0];
         exp_addr = exp_we ? 32'h400 + 32'(4 * (acc / 2)) : 32'h300 + 32'(4 * (acc / 2));
         exp_wd   = exp_we ? pat(32'h300 + 32'(4 * (acc / 2))) : 32'd0;
         for (int c = 0; c < 3; c++) begin
            check($sformatf("c_acc%0d_c%0d_req", acc, c),  32'(bus.mem_req), 32'd1);
            check($sformatf("c_acc%0d_c%0d_addr", acc, c), bus.mem_addr,     exp_addr);
            check($sformatf("c_acc%0d_c%0d_we", acc, c),   32'(bus.mem_we),  32'(exp_we));
            check($sformatf("c_acc%0d_c%0d_wd", acc, c),   bus.mem_wd,       exp_wd);
            tick();
         end
      end
      check("c_finish_req", 32'(bus.mem_req), 32'd0);
      tick();
      check_reg("c_ctrl_done", 2'd0, 32'h4);
      check("c_nwrites", 32'(wr_addr_q.size() - bw), 32'd2);
      check_reg("c_src", 2'd1, 32'h308);
      check_reg("c_dst", 2'd2, 32'h408);
      gnt_mode = 1'b0;
      cfg_write(2'd0, 32'h4);

      // address wrap at the top of memory
      bw = wr_addr_q.size();
      br = rd_addr_q.size();
      cfg_write(2'd1, 32'hFFFF_FFFC);
      cfg_write(2'd2, 32'h0);
      cfg_write(2'd3, 32'd2);
      cfg_write(2'd0, 32'h1);
      wait_done(20, cyc);
      check("d_done",    32'(bus.cfg_rd[2]), 32'd1);
      check("d_latency", 32'(cyc),           32'd5);
      check("d_nreads",  32'(rd_addr_q.size() - br), 32'd2);
      check("d_nwrites", 32'(wr_addr_q.size() - bw), 32'd2);
      if (rd_addr_q.size() - br == 2 && wr_addr_q.size() - bw == 2) begin
         check("d_rd0",      rd_addr_q[br],     32'hFFFF_FFFC);
         check("d_rd1",      rd_addr_q[br + 1], 32'h0);
         check("d_wr0_addr", wr_addr_q[bw],     32'h0);
         check("d_wr0_data", wr_data_q[bw],     pat(32'hFFFF_FFFC));
         check("d_wr1_addr", wr_addr_q[bw + 1], 32'h4);
         check("d_wr1_data", wr_data_q[bw + 1], pat(32'h0));
      end
      check_reg("d_src", 2'd1, 32'h4);
      check_reg("d_dst", 2'd2, 32'h8);
      cfg_write(2'd0, 32'h4);

      // busy-time writes ignored, CTRL start ignored, then abort in WRITE with grant
      bw = wr_addr_q.size();
      cfg_write(2'd1, 32'h500);
      cfg_write(2'd2, 32'h600);
      cfg_write(2'd3, 32'd4);
      cfg_write(2'd0, 32'h1);
      repeat (3) tick();
      check("f_in_write", 32'(bus.mem_we), 32'd1);
      cfg_write(2'd1, 32'h999);
      cfg_write(2'd3, 32'd7);
      cfg_write(2'd0, 32'h3);
      check_reg("f_ctrl_busy", 2'd0, 32'h3);
      check_reg("f_len_mid",   2'd3, 32'd1);
      check_reg("f_src_mid",   2'd1, 32'h50C);
      tick();
      check("f_nwrites", 32'(wr_addr_q.size() - bw), 32'd3);
      check("f_write_again", 32'(bus.mem_we), 32'd1);
      cfg_write(2'd0, 32'h0);
      check("f_abort_req", 32'(bus.mem_req), 32'd0);
      check_reg("f_ctrl", 2'd0, 32'h0);
      check_reg("f_len",  2'd3, 32'd1);
      check_reg("f_src",  2'd1, 32'h50C);
      check_reg("f_dst",  2'd2, 32'h60C);
      brq = req_q.size();
      repeat (3) tick();
      check("f_no_req_after", 32'(req_q.size() - brq), 32'd0);

      // reset pulse while a read is stalled
      gnt_mode = 1'b1;
      bw = wr_addr_q.size();
      cfg_write(2'd1, 32'h700);
      cfg_write(2'd2, 32'h800);
      cfg_write(2'd3, 32'd2);
      cfg_write(2'd0, 32'h3);
      tick();
      check("g_stalled_read", bus.mem_addr, 32'h700);
      reset = 1'b1;
      #1;
      check("g_rst_req",  32'(bus.mem_req), 32'd0);
      check("g_rst_addr", bus.mem_addr,     32'd0);
      #3;
      reset    = 1'b0;
      gnt_mode = 1'b0;
      brq = req_q.size();
      repeat (4) tick();
      check("g_no_req",    32'(req_q.size() - brq), 32'd0);
      check("g_no_write",  32'(wr_addr_q.size() - bw), 32'd0);
      check_reg("g_ctrl",  2'd0, 32'h0);
      check_reg("g_src",   2'd1, 32'h0);
      check_reg("g_dst",   2'd2, 32'h0);
      check_reg("g_len",   2'd3, 32'h0);
      check("g_irq",       32'(bus.irq), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
